// File: rtl/stream_to_credit_valid.sv
// rtl/stream_to_credit_valid.sv - ready/valid stream to credit-limited valid-only pulse link
// Optional macro STREAM_TO_CREDIT_VALID_OVF_CHECK_EN: sticky err_o plus assertion on credit overflow.
module stream_to_credit_valid #(
  parameter type T          = logic,
  parameter int  NumCredits = 4,
  parameter int  MinGap     = 0,
  parameter int  CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  T                    data_i,
  output logic                valid_o,
  output T                    data_o,
  input  logic                credit_i,
  output logic [CntWidth-1:0] credits_o,
  output logic                busy_o,
  output logic                err_o
);
  localparam int GapWidth = (MinGap > 0) ? $clog2(MinGap + 1) : 1;
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(NumCredits);
  localparam logic [GapWidth-1:0] GapLoad = GapWidth'(MinGap);

  T                    r_stage;
  logic                r_stage_valid;
  logic [CntWidth-1:0] r_cnt;
  logic [GapWidth-1:0] r_gap;
  logic                r_valid;
  T                    r_data;

  logic w_send;
  logic w_accept;
  logic w_full;

  assign w_full   = (r_cnt == MaxCnt);
  assign w_send   = r_stage_valid && (r_cnt != '0) && (r_gap == '0);
  assign ready_o  = !r_stage_valid || w_send;
  assign w_accept = valid_i && ready_o;

  assign valid_o   = r_valid;
  assign data_o    = r_data;
  assign credits_o = r_cnt;
  assign busy_o    = r_stage_valid || !w_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stage       <= '0;
      r_stage_valid <= 1'b0;
      r_cnt         <= MaxCnt;
      r_gap         <= '0;
      r_valid       <= 1'b0;
      r_data        <= '0;
    end else begin
      r_valid <= w_send;
      if (w_send) begin
        r_data <= r_stage;
      end

      if (w_accept) begin
        r_stage       <= data_i;
        r_stage_valid <= 1'b1;
      end else if (w_send) begin
        r_stage_valid <= 1'b0;
      end

      // A credit arriving while full is dropped, so the counter saturates.
      if (w_send && !credit_i) begin
        r_cnt <= r_cnt - CntWidth'(1);
      end else if (!w_send && credit_i && !w_full) begin
        r_cnt <= r_cnt + CntWidth'(1);
      end

      if (w_send) begin
        r_gap <= GapLoad;
      end else if (r_gap != '0) begin
        r_gap <= r_gap - GapWidth'(1);
      end
    end
  end

`ifdef STREAM_TO_CREDIT_VALID_OVF_CHECK_EN
  logic w_ovf;
  logic r_err;

  assign w_ovf = credit_i && !w_send && w_full;
  assign err_o = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_ovf) begin
      r_err <= 1'b1;
    end
  end

  a_no_credit_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !w_ovf)
    else $error("credit returned while credit counter already full");
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_stream_to_credit_valid.sv
// tb/tb_stream_to_credit_valid.sv - randomized self-checking bench for stream_to_credit_valid
module tb_stream_to_credit_valid;
  localparam int N = 4;
`ifdef STREAM_TO_CREDIT_VALID_OVF_CHECK_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       vi   [2];
  logic [7:0] di   [2];
  logic       cr   [2];
  logic       ro   [2];
  logic       vo   [2];
  logic [7:0] dout [2];
  logic [2:0] co   [2];
  logic       bo   [2];
  logic       eo   [2];

  stream_to_credit_valid #(.T(logic [7:0]), .NumCredits(N), .MinGap(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(vi[0]), .ready_o(ro[0]), .data_i(di[0]),
    .valid_o(vo[0]), .data_o(dout[0]), .credit_i(cr[0]), .credits_o(co[0]),
    .busy_o(bo[0]), .err_o(eo[0])
  );

  stream_to_credit_valid #(.T(logic [7:0]), .NumCredits(N), .MinGap(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(vi[1]), .ready_o(ro[1]), .data_i(di[1]),
    .valid_o(vo[1]), .data_o(dout[1]), .credit_i(cr[1]), .credits_o(co[1]),
    .busy_o(bo[1]), .err_o(eo[1])
  );

  int         gap_cfg [2] = '{0, 3};
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;

  // reference model: one-slot holding stage, credit balance, idle-gap countdown
  int         m_cnt [2];
  int         m_gap [2];
  int         m_out [2];
  bit         m_stv [2];
  logic [7:0] m_std [2];
  bit         m_vo  [2];
  logic [7:0] m_do  [2];
  bit         m_err [2];

  logic [7:0] src_buf [2][0:1023];
  int         src_head [2];
  int         src_tail [2];

  int         pulses   [2];
  logic [7:0] last_dat [2];
  int         last_pc  [2];
  int         ivl_min  [2];
  int         ivl_max  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_send(input int i);
    return m_stv[i] && (m_cnt[i] != 0) && (m_gap[i] == 0);
  endfunction

  task automatic clr_stats(input int i);
    last_pc[i] = -1;
    ivl_min[i] = 9999;
    ivl_max[i] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = N;  m_gap[i] = 0;  m_out[i] = 0;
      m_stv[i] = 0;  m_std[i] = '0; m_vo[i]  = 0;
      m_do[i]  = '0; m_err[i] = 0;
      src_head[i] = 0; src_tail[i] = 0;
      vi[i] = 1'b0; di[i] = '0; cr[i] = 1'b0;
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    src_buf[i][src_tail[i]] = d;
    src_tail[i]++;
    vi[i] = 1'b1;
    di[i] = src_buf[i][src_head[i]];
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("ready%0d", i), 32'(ro[i]), 32'(!m_stv[i] || m_send(i)));
      check_eq($sformatf("credits%0d", i), 32'(co[i]), 32'(m_cnt[i]));
      check_eq($sformatf("busy%0d", i), 32'(bo[i]), 32'(m_stv[i] || m_cnt[i] != N));
      check_eq($sformatf("valid%0d", i), 32'(vo[i]), 32'(m_vo[i]));
      if (m_vo[i]) check_eq($sformatf("data%0d", i), 32'(dout[i]), 32'(m_do[i]));
      check_eq($sformatf("err%0d", i), 32'(eo[i]), 32'(m_err[i]));
      if (vo[i] === 1'b1) begin
        pulses[i]++;
        last_dat[i] = dout[i];
        if (last_pc[i] >= 0) begin
          if (cyc - last_pc[i] < ivl_min[i]) ivl_min[i] = cyc - last_pc[i];
          if (cyc - last_pc[i] > ivl_max[i]) ivl_max[i] = cyc - last_pc[i];
        end
        last_pc[i] = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit s, acc;
        s   = m_send(i);
        acc = vi[i] && (!m_stv[i] || s);
        m_vo[i] = s;
        if (s) m_do[i] = m_std[i];
        if (acc) begin
          m_stv[i] = 1;
          m_std[i] = di[i];
          src_head[i]++;
        end else if (s) begin
          m_stv[i] = 0;
        end
        m_cnt[i] = m_cnt[i] - int'(s) + int'(cr[i]);
        if (m_cnt[i] > N) begin
          m_cnt[i] = N;
          if (OvfEn) m_err[i] = 1;
        end
        m_gap[i] = s ? gap_cfg[i] : (m_gap[i] > 0 ? m_gap[i] - 1 : 0);
        m_out[i] += int'(s);
        if (cr[i] && m_out[i] > 0) m_out[i]--;
        vi[i] = (src_head[i] < src_tail[i]);
        di[i] = src_buf[i][src_head[i]];
        cr[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int i);
    bit done;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (src_head[i] == src_tail[i] && !m_stv[i] && m_out[i] == 0) begin
        done = 1;
      end else begin
        cr[i] = (m_out[i] > 0);
        cycle();
      end
    end
    check_eq($sformatf("drain%0d_done", i), 32'(done), 32'd1);
    src_head[i] = 0;
    src_tail[i] = 0;
  endtask

  initial begin
    int c, p0;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      pulses[i] = 0;
      last_dat[i] = '0;
      clr_stats(i);
    end
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();
    check_eq("rst_credits", 32'(co[0]), 32'd4);
    check_eq("rst_ready", 32'(ro[0]), 32'd1);
    check_eq("rst_busy", 32'(bo[0]), 32'd0);

    // six items with no credits returned: four go out, one parks, one waits
    p0 = pulses[0];
    for (int k = 0; k < 6; k++) push(0, 8'(k));
    repeat (10) cycle();
    check_eq("nocred_pulses", 32'(pulses[0] - p0), 32'd4);
    check_eq("nocred_last", 32'(last_dat[0]), 32'd3);
    check_eq("nocred_credits", 32'(co[0]), 32'd0);
    check_eq("nocred_ready", 32'(ro[0]), 32'd0);

    c  = cyc;
    p0 = pulses[0];
    cr[0] = 1'b1;
    repeat (4) cycle();
    check_eq("credit_pulse_cyc", 32'(last_pc[0]), 32'(c + 2));
    check_eq("credit_pulse_data", 32'(last_dat[0]), 32'd4);
    check_eq("credit_pulse_cnt", 32'(pulses[0] - p0), 32'd1);
    check_eq("credit_after", 32'(co[0]), 32'd0);
    drain(0);

    // hold the credit count at 2 while every send is matched by a returned credit
    push(0, 8'd100);
    push(0, 8'd101);
    repeat (6) cycle();
    check_eq("bal_pre_credits", 32'(co[0]), 32'd2);
    for (int k = 0; k < 30; k++) push(0, 8'(200 + k));
    for (int k = 0; k < 25; k++) begin
      if (k == 5) p0 = pulses[0];
      cr[0] = m_send(0);
      cycle();
    end
    check_eq("bal_pulses", 32'(pulses[0] - p0), 32'd20);
    check_eq("bal_credits", 32'(co[0]), 32'd2);
    drain(0);

    // MinGap=3 instance with a continuous stream and ample credits
    clr_stats(1);
    p0 = pulses[1];
    for (int k = 0; k < 12; k++) push(1, 8'(50 + k));
    for (int k = 0; k < 80 && (pulses[1] - p0) < 12; k++) begin
      cr[1] = (m_out[1] > 0);
      cycle();
    end
    check_eq("gap_pulses", 32'(pulses[1] - p0), 32'd12);
    check_eq("gap_ivl_min", 32'(ivl_min[1]), 32'd4);
    check_eq("gap_ivl_max", 32'(ivl_max[1]), 32'd4);
    check_eq("gap_last", 32'(last_dat[1]), 32'd61);
    drain(1);

    // random traffic on both instances with an asynchronous reset in the middle
    for (int k = 0; k < 400; k++) begin
      if (k == 250) begin
        rst = 1'b1;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (src_tail[i] - src_head[i] < 3 && $urandom_range(0, 1) == 1)
          push(i, 8'($urandom_range(0, 255)));
        cr[i] = (m_out[i] > 0) && ($urandom_range(0, 2) == 0);
      end
      cycle();
    end
    drain(0);
    drain(1);

    // credit returned while already full and idle
    cr[0] = 1'b1;
    cycle();
    cycle();
    check_eq("ovf_err", 32'(eo[0]), 32'(OvfEn));
    check_eq("ovf_credits", 32'(co[0]), 32'd4);
    repeat (3) cycle();
    check_eq("ovf_err_sticky", 32'(eo[0]), 32'(OvfEn));
    rst = 1'b1;
    model_reset();
    cycle();
    rst = 1'b0;
    cycle();
    check_eq("ovf_err_cleared", 32'(eo[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_to_credit_valid.md
# stream_to_credit_valid

Transmitter end of a valid-only (no backpressure) link: accepts a ready/valid stream and emits single-cycle valid pulses to a downstream consumer that cannot stall, never sending more items than the consumer has buffer slots for. Flow control uses credits: the consumer returns one `credit_i` pulse per slot it frees. Sits at the producer side of a lossless valid-only interface, opposite a lossy valid-to-stream receiver, so items are never dropped.

## Interface
- `T`, default `logic`: payload type.
- `NumCredits`, default 4: consumer buffer depth, which is also the initial credit count. Must be ≥1.
- `MinGap`, default 0: minimum number of idle cycles between two `valid_o` pulses.
- `CntWidth`, default `$clog2(NumCredits+1)`: derived parameter, not to be overridden.

Ports (reset is asynchronous and active-high):
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous active-high reset.
- `valid_i` in 1: input stream valid.
- `ready_o` out 1: input stream ready.
- `data_i` in `T`: input payload.
- `valid_o` out 1: output pulse; the consumer must accept it.
- `data_o` out `T`: output payload, meaningful only while `valid_o` is high.
- `credit_i` in 1: one credit returned per cycle it is high.
- `credits_o` out `CntWidth`: current credit count.
- `busy_o` out 1: an item is held locally or unreturned credits are outstanding.
- `err_o` out 1: sticky credit-overflow flag (see Configuration).

## Operation
- State:
  - one-entry stage register (`stage_q`, `stage_valid_q`);
  - credit counter `cnt_q` in the range 0..NumCredits;
  - gap counter `gap_q` in the range 0..MinGap;
  - output registers `valid_o`, `data_o`;
  - `err_o`.
- Send condition (combinational): `send = stage_valid_q && cnt_q != 0 && gap_q == 0`.
- `ready_o = !stage_valid_q || send`. Accept happens when `valid_i && ready_o`.
- Next-state rules at each clock edge:
  - `valid_o <= send`.
  - When `send` is high, `data_o <= stage_q`; otherwise `data_o` holds its value.
  - Stage: on accept it loads `data_i` and is set valid. If `send` is high without an accept, the stage is cleared. Otherwise it holds.
  - Credit count: `cnt_q <= cnt_q - send + credit_i`. A simultaneous `send` and `credit_i` leaves it unchanged. `cnt_q` never goes below 0, because `send` requires `cnt_q != 0`.
  - Credit overflow: if `credit_i` is high, `send` is low and `cnt_q == NumCredits`, the credit is discarded and `cnt_q` stays at NumCredits.
  - Gap counter: on `send`, `gap_q <= MinGap`. Otherwise, if `gap_q != 0`, it decrements.
- `credits_o = cnt_q`.
- `busy_o = stage_valid_q || cnt_q != NumCredits`.
- Input stream rules: once `valid_i` is raised it must hold, with `data_i` stable, until accepted. `ready_o` may depend combinationally on `credit_i` only through the registered `cnt_q`, i.e. it does not depend on it.

## Timing
- Reset values:
  - `cnt_q = NumCredits`, `stage_valid_q = 0`, `gap_q = 0`;
  - `valid_o = 0`, `data_o = '0`, `err_o = 0`;
  - `ready_o = 1` immediately once reset is released.
- Latency: an item accepted at edge k appears on `valid_o` in the cycle after edge k+1, i.e. 2 cycles, provided credit is available and `gap_q == 0`.
- Throughput:
  - MinGap=0 with credits available: 1 item per cycle, with `ready_o` held high continuously.
  - MinGap=g: at most 1 item per g+1 cycles.
- No credits (`cnt_q == 0`): the stage holds its item and `ready_o` stays low. A `credit_i` pulse in cycle c allows `send` in cycle c+1 (cnt becomes 1 at edge c), so `valid_o` rises in cycle c+2.
- Reset asserted mid-operation: all state clears asynchronously. Any held item is lost and credits are restored to NumCredits. The consumer must be reset together with this block.
- `valid_o` is always a single-cycle pulse per item and is never high for more than one item per cycle.

## Configuration
- `STREAM_TO_CREDIT_VALID_OVF_CHECK_EN`
- Defined:
  - `err_o` is set on the edge after any credit overflow event (`credit_i` high, `send` low, `cnt_q == NumCredits`) and stays set until reset.
  - A simulation assertion fires an `$error` on the same event.
- Undefined:
  - `err_o` is tied to 0 and no assertion is compiled.
  - Overflow credits are still discarded (saturating counter).

## Test plan
- Reset then idle, NumCredits=4: `credits_o == 4`, `valid_o == 0`, `ready_o == 1`, `busy_o == 0`.
- Send items 0..5 back-to-back with no `credit_i`, MinGap=0:
  - exactly 4 `valid_o` pulses on consecutive cycles carry 0,1,2,3;
  - `credits_o` reaches 0, item 4 sits in the stage, and `ready_o` stays low while item 5 is held at the input.
- From that state, pulse `credit_i` once at cycle c: one pulse with `data_o == 4` in cycle c+2, `credits_o == 0` afterwards.
- Simultaneous `send` and `credit_i` for 20 cycles with `cnt_q == 2`: `credits_o` stays 2 and the output is gap-free.
- MinGap=3, a continuous input stream and ample credits: `valid_o` pulses exactly every 4 cycles, in order, with no item lost.
- With the macro defined: a `credit_i` pulse while `credits_o == 4` and idle sets `err_o` to 1 on the next edge and keeps `credits_o == 4`; `err_o` stays 1 until `rst_i`. With the macro undefined: `err_o` stays 0.
